dm_byte_sequencer: RTL
======================

# dm_byte_sequencer

Byte-serial access sequencer that sits directly upstream of the byte-organised data memory in the single-cycle core's load/store path. It accepts one load or store request from the core and encodes it as 1, 2 or 4 byte beats on an 8-bit memory port, using the core's funct3 DMCtrl encoding. For loads it reassembles the returned bytes little-endian, applies sign or zero extension, and returns a 32-bit result with a one-cycle response strobe. A ready/valid handshake lets the core stall while a transfer is in flight.

## Interface
- ADDR_W, 32, width of mem_addr; the low ADDR_W bits of DMAddress are used, and beat addresses wrap modulo 2^ADDR_W.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  sequencer can accept a request (IDLE only).
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- DMAddress  in  32  byte address of the first beat.
- DMDataWr  in  32  store data; bits 7:0 are written first.
- resp_valid  out  1  one-cycle strobe marking request completion.
- resp_err  out  1  valid with resp_valid; 1 = illegal DMCtrl.
- DMDataRd  out  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_en  out  1  byte beat active this cycle.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  beat byte address.
- mem_wdata  out  8  beat write byte.
- mem_rdata  in  8  read byte; valid the cycle after a read beat (synchronous read).

## Operation
- States: IDLE, BEAT, DRAIN, RESP. The reset state is IDLE.
- **Reset values:** req_ready=1 and all other outputs 0; internal address, data and count registers are 0.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch DMWr, DMCtrl, DMAddress and DMDataWr, and clear the beat counter k.
  - Beat count n: 1 for 000/100, 2 for 001/101, 4 for 010.
  - Legal DMCtrl → BEAT.
  - Illegal DMCtrl (011, 110, 111) → RESP with the error flag set; no memory beat is issued.
- **BEAT:**
  - mem_en=1, mem_we=latched DMWr, mem_addr=(addr+k) mod 2^ADDR_W, mem_wdata=data[8k+7:8k].
  - k increments each cycle.
  - After beat n-1: store → RESP; load → DRAIN.
- **Read capture:** for each read beat k, the mem_rdata returned on the following cycle is registered into byte lane k of the assembly register. This covers beats during BEAT and the last beat's data during DRAIN.
- **DRAIN:** mem_en=0; captures the final byte, then → RESP.
- **RESP:**
  - resp_valid=1 for exactly one cycle; resp_err as latched.
  - DMDataRd for loads:
    - 000: byte lane 0 sign-extended from bit 7.
    - 001: lanes 1:0 sign-extended from bit 15.
    - 010: all four lanes, no extension.
    - 100 / 101: zero-extended.
  - DMDataRd=0 for stores and errors.
  - → IDLE.
- req_valid is ignored whenever req_ready=0; the latched request is immune to input changes.
- No alignment restriction; a multi-byte access crossing 2^ADDR_W wraps to address 0.
- **Reset mid-transfer:** immediate return to IDLE with all outputs at reset values; bytes already written stay in memory; no response is produced.

## Timing
- Acceptance edge T (req_valid && req_ready).
- Beats occupy cycles T+1 .. T+n.
- Store: resp_valid in cycle T+n+1; next acceptance at the edge ending T+n+2.
  - Byte store: 2 cycles to response, 3 cycles per request.
- Load: DRAIN in T+n+1, resp_valid in T+n+2.
  - Word load: 6 cycles to response, 7 cycles per request.
- Illegal DMCtrl: resp_valid in T+1.
- mem_en is high for exactly n consecutive cycles per legal request and never in IDLE, DRAIN or RESP.
- DMDataRd and resp_* are registered, with no combinational path from mem_rdata.

## Test plan
- **Reset:** assert rst_n=0 mid word-load beat 2 → outputs zero immediately; req_ready=1 after release; no resp_valid ever seen.
- **Word store:** DMWr=1, DMCtrl=010, DMAddress=0x10, DMDataWr=0xA1B2C3D4 → beats 0x10:D4, 0x11:C3, 0x12:B2, 0x13:A1 at T+1..T+4; resp_valid at T+5; DMDataRd=0.
- **Word load:** read back the same address with DMCtrl=010 → 4 read beats; resp_valid at T+6; DMDataRd=0xA1B2C3D4.
- **Extension:** memory byte 0x13=0xA1; lb → 0xFFFFFFA1, lbu → 0x000000A1. Half at 0x12: lh → 0xFFFFA1B2, lhu → 0x0000A1B2.
- **Illegal DMCtrl / wrap:**
  - DMCtrl=011 → resp_valid and resp_err at T+1, no mem_en.
  - ADDR_W=6, word store at 0x3E → beat addresses 0x3E, 0x3F, 0x00, 0x01.
- **Busy-ignore:** toggle req_valid with new fields during a word store → req_ready stays 0; only the original transfer occurs, unchanged.

Source files
------------

// File: rtl/dm_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dm_byte_sequencer
// Purpose  : Byte-serial load/store sequencer between the core's data-memory
//            request port and an 8-bit synchronous-read memory. One request
//            is broken into 1, 2 or 4 byte beats (little-endian). Load bytes
//            are reassembled, sign/zero extended and returned with a
//            one-cycle response strobe.
// Ports    :
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready request handshake (ready only while idle)
//   DMWr, DMCtrl          1 = store; funct3 size/extension code
//   DMAddress, DMDataWr   first-beat byte address; store data (7:0 first)
//   resp_valid, resp_err  completion strobe; illegal-DMCtrl flag
//   DMDataRd              extended load result (0 for stores / errors)
//   mem_en, mem_we        byte beat active; beat is a write
//   mem_addr, mem_wdata   beat byte address (wraps mod 2^ADDR_W); write byte
//   mem_rdata             read byte, valid the cycle after a read beat
// Revision : 1.0 - initial release
// ============================================================================
module dm_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              DMWr,
   input  logic [2:0]        DMCtrl,
   input  logic [31:0]       DMAddress,
   input  logic [31:0]       DMDataWr,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       DMDataRd,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_BEAT  = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;
   localparam logic [1:0] c_ST_RESP  = 2'd3;

   localparam logic [2:0] c_CTRL_LB  = 3'b000;
   localparam logic [2:0] c_CTRL_LH  = 3'b001;
   localparam logic [2:0] c_CTRL_LW  = 3'b010;
   localparam logic [2:0] c_CTRL_LBU = 3'b100;
   localparam logic [2:0] c_CTRL_LHU = 3'b101;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;

   logic              r_wr;          // latched DMWr
   logic [2:0]        r_ctrl;        // latched DMCtrl
   logic [ADDR_W-1:0] r_addr;        // latched first-beat address
   logic [31:0]       r_data;        // latched store data
   logic [1:0]        r_k;           // current beat index
   logic [1:0]        r_nlast;       // index of the final beat (n-1)

   logic              r_rd_pend;     // a read beat was issued last cycle
   logic [1:0]        r_rd_lane;     // byte lane that read beat belongs to
   logic [31:0]       r_asm;         // little-endian load assembly register

   logic              r_resp_valid;
   logic              r_resp_err;
   logic [31:0]       r_rdata;

   // ------------------------------------------------------------------------
   // Request decode (combinational, on the live request inputs)
   // ------------------------------------------------------------------------
   logic              w_accept;
   logic              w_ctrl_legal;
   logic [1:0]        w_nlast_in;

   assign w_accept = (r_state == c_ST_IDLE) && req_valid;

   always_comb begin
      w_ctrl_legal = 1'b1;
      w_nlast_in   = 2'd0;
      case (DMCtrl)
         c_CTRL_LB, c_CTRL_LBU: w_nlast_in = 2'd0;
         c_CTRL_LH, c_CTRL_LHU: w_nlast_in = 2'd1;
         c_CTRL_LW:             w_nlast_in = 2'd3;
         default:               w_ctrl_legal = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Load assembly and extension
   // ------------------------------------------------------------------------
   // The final read byte arrives in DRAIN; it is merged here so the result
   // register can be loaded on the same edge that leaves DRAIN. mem_rdata
   // only ever reaches DMDataRd through r_rdata.
   logic [31:0] w_asm_merged;
   logic [31:0] w_ext;

   always_comb begin
      w_asm_merged = r_asm;
      w_asm_merged[{r_rd_lane, 3'b000} +: 8] = mem_rdata;
   end

   always_comb begin
      w_ext = 32'h0;
      case (r_ctrl)
         c_CTRL_LB:  w_ext = {{24{w_asm_merged[7]}},  w_asm_merged[7:0]};
         c_CTRL_LH:  w_ext = {{16{w_asm_merged[15]}}, w_asm_merged[15:0]};
         c_CTRL_LW:  w_ext = w_asm_merged;
         c_CTRL_LBU: w_ext = {24'h0, w_asm_merged[7:0]};
         c_CTRL_LHU: w_ext = {16'h0, w_asm_merged[15:0]};
         default:    w_ext = 32'h0;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (req_valid) begin
               // Illegal sizes skip the memory entirely and report at once.
               w_state_nxt = w_ctrl_legal ? c_ST_BEAT : c_ST_RESP;
            end
         end
         c_ST_BEAT: begin
            if (r_k == r_nlast) begin
               // Loads need one extra cycle for the last synchronous read.
               w_state_nxt = r_wr ? c_ST_RESP : c_ST_DRAIN;
            end
         end
         c_ST_DRAIN: w_state_nxt = c_ST_RESP;
         c_ST_RESP:  w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output logic
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] w_beat_addr;

   // Natural ADDR_W-bit overflow gives the required wrap to address 0.
   assign w_beat_addr = r_addr + ADDR_W'(r_k);

   always_comb begin
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 8'h00;
      case (r_state)
         c_ST_IDLE: req_ready = 1'b1;
         c_ST_BEAT: begin
            mem_en    = 1'b1;
            mem_we    = r_wr;
            mem_addr  = w_beat_addr;
            mem_wdata = r_data[{r_k, 3'b000} +: 8];
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign DMDataRd   = r_rdata;

   // ------------------------------------------------------------------------
   // Request latch, beat counter and read capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr      <= 1'b0;
         r_ctrl    <= 3'b000;
         r_addr    <= '0;
         r_data    <= 32'h0;
         r_k       <= 2'd0;
         r_nlast   <= 2'd0;
         r_rd_pend <= 1'b0;
         r_rd_lane <= 2'd0;
         r_asm     <= 32'h0;
      end else begin
         if (w_accept) begin
            r_wr    <= DMWr;
            r_ctrl  <= DMCtrl;
            r_addr  <= DMAddress[ADDR_W-1:0];
            r_data  <= DMDataWr;
            r_k     <= 2'd0;
            r_nlast <= w_nlast_in;
            r_asm   <= 32'h0;
         end else if (r_state == c_ST_BEAT) begin
            r_k <= r_k + 2'd1;
         end

         // Each read beat's byte shows up one cycle later; remember which
         // lane it belongs to so the capture lines up with the beat.
         r_rd_pend <= (r_state == c_ST_BEAT) && !r_wr;
         r_rd_lane <= r_k;
         if (r_rd_pend) begin
            r_asm <= w_asm_merged;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registered response
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rdata      <= 32'h0;
      end else begin
         r_resp_valid <= (w_state_nxt == c_ST_RESP);
         // The only path from IDLE straight to RESP is an illegal DMCtrl.
         r_resp_err   <= (w_state_nxt == c_ST_RESP) && (r_state == c_ST_IDLE);
         // Only loads leave through DRAIN; stores and errors return zero.
         if ((w_state_nxt == c_ST_RESP) && (r_state == c_ST_DRAIN)) begin
            r_rdata <= w_ext;
         end else begin
            r_rdata <= 32'h0;
         end
      end
   end

endmodule
`default_nettype wire
